icape2_iprog_ctrl: RTL and testbench
====================================

# icape2_iprog_ctrl

Sequencer that drives the Artix-7 ICAPE2 primitive to trigger a warm-boot (IPROG) into the bitstream at a configurable SPI flash address.
- Debounces the board key, then issues the fixed 8-word WBSTAR/IPROG command sequence on the ICAPE2 write port, one word per clock.
- Sits between the key input of the register-write top level and the ICAPE2 instance; its outputs connect directly to ICAPE2 CSIB/RDWRB/I.

## Interface
- WBSTAR_ADDR, 32'h0040_0000, warm-boot start address written to WBSTAR.
- DEBOUNCE_CYCLES, 1_000_000, consecutive synchronized-high cycles that qualify a key press (≥2).
- clk  input  1  system clock, ≤100 MHz (ICAPE2 limit); all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key  input  1  asynchronous push-button, active-high.
- icap_csib  output  1  ICAPE2 chip select, active-low.
- icap_rdwrb  output  1  ICAPE2 direction; 0 = write.
- icap_i  output  32  ICAPE2 write data.
- busy  output  1  high while a sequence is in progress.
- done  output  1  one-cycle pulse after a completed sequence.

## Operation
- key passes through a 2-flop synchronizer → key_s.
- Debounce counter: cleared whenever key_s=0; increments while key_s=1, saturating at DEBOUNCE_CYCLES.
- The fire condition is a combinational strobe asserted when key_s=1 and the counter is DEBOUNCE_CYCLES-1, i.e. on the cycle whose clock edge takes the counter to DEBOUNCE_CYCLES; at most one fire per press.
- Re-arm requires key_s=0 for at least one cycle.
- A fire while busy=1 is discarded, not queued.
- FSM states:
  - IDLE: csib=1, rdwrb=1. The edge that takes the counter to DEBOUNCE_CYCLES moves IDLE → SETUP.
  - SETUP (1 cycle): csib=1, rdwrb=0, busy=1.
  - WRITE (8 cycles, index k=0..7): csib=0, rdwrb=0, icap_i=word[k].
  - HOLD (1 cycle): csib=1, rdwrb=0.
  - DONE (1 cycle): done=1, busy=0, csib=1, rdwrb=1 → IDLE.
- Word table:
  - 0: FFFFFFFF (dummy)
  - 1: AA995566 (sync)
  - 2: 20000000 (NOOP)
  - 3: 30020001 (write WBSTAR)
  - 4: WBSTAR_ADDR
  - 5: 30008001 (write CMD)
  - 6: 0000000F (IPROG)
  - 7: 20000000 (NOOP)
- icap_i holds its last value outside WRITE.
- All outputs are registered.

## Timing
- Reset values: icap_csib=1, icap_rdwrb=1, icap_i=0, busy=0, done=0, FSM=IDLE, counter=0, synchronizer=0.
- Let e0 be the first edge sampling key=1. busy rises after edge e0+D+1; the first icap_csib=0 with word 0 appears after edge e0+D+2, where D=DEBOUNCE_CYCLES.
- busy stays high for exactly 10 cycles (SETUP+8 WRITE+HOLD); done pulses the cycle after busy falls.
- icap_rdwrb is 0 one cycle before csib falls and one cycle after csib rises (ICAPE2 setup/hold on RDWRB).
- csib stays low for exactly 8 contiguous cycles, with no gaps.
- rst mid-operation: the next edge restores all reset values. The sequence is abandoned with no done pulse and no resume.
- After reset, a key still held high counts as a new press and fires after the full debounce.
- key bouncing low during the debounce window restarts the count from 0.

## Configuration
- ICAPE2_BITSWAP_EN defined: icap_i presents each word with bits reversed within every byte, as ICAPE2 requires (e.g. AA995566 → 5599AA66, 30020001 → 0C400080).
- Undefined: words are output unswapped. This mode is for simulation readability only; the resulting bitstream is not functional on hardware.

## Test plan
- Reset held 5 cycles → icap_csib=1, icap_rdwrb=1, icap_i=0, busy=0, done=0 on every cycle.
- DEBOUNCE_CYCLES=4, key held high, macro undefined:
  - csib=0 for 8 cycles carrying FFFFFFFF, AA995566, 20000000, 30020001, 00400000, 30008001, 0000000F, 20000000;
  - csib falls after edge e0+6; busy high 10 cycles, then one done pulse.
- DEBOUNCE_CYCLES=4, key high 3 cycles then low, repeated 5 times → csib never low, busy never high.
- key held high 200 cycles → exactly one sequence. Release 2 cycles, press again → a second identical sequence.
- rst asserted while icap_i=30020001 → next cycle csib=1, rdwrb=1, busy=0; no done pulse. key still high → a fresh sequence after the debounce.
- ICAPE2_BITSWAP_EN defined, key press → words 0..3 appear as FFFFFFFF, 5599AA66, 04000000, 0C400080.

Source files
------------

// File: rtl/icape2_iprog_ctrl.sv
// icape2_iprog_ctrl: debounced key press triggers the ICAPE2 WBSTAR/IPROG warm-boot sequence.
// Define ICAPE2_BITSWAP_EN to bit-reverse each byte of icap_i as ICAPE2 expects on hardware.
module icape2_iprog_ctrl #(
  parameter logic [31:0] WBSTAR_ADDR     = 32'h0040_0000,
  parameter int          DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q;
  logic          csib_q, csib_d, rdwrb_q, rdwrb_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]   data_q, data_d;
  logic          key_s, fire, act;

  function automatic logic [31:0] word(input logic [2:0] k);
    logic [31:0] w, r;
    case (k)
      3'd0:    w = 32'hFFFF_FFFF;
      3'd1:    w = 32'hAA99_5566;
      3'd2:    w = 32'h2000_0000;
      3'd3:    w = 32'h3002_0001;
      3'd4:    w = WBSTAR_ADDR;
      3'd5:    w = 32'h3000_8001;
      3'd6:    w = 32'h0000_000F;
      default: w = 32'h2000_0000;
    endcase
`ifdef ICAPE2_BITSWAP_EN
    for (int b = 0; b < 32; b++) r[b] = w[(b / 8) * 8 + 7 - (b % 8)];
`else
    r = w;
`endif
    return r;
  endfunction

  assign key_s = sync_q[1];
  // fire only on the edge that lands the counter on its saturation value: one per press
  assign fire  = key_s && (cnt_q == CNT_FIRE);
  assign cnt_d = !key_s ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE:  state_d = fire ? SETUP : IDLE;
      SETUP: begin
        state_d = WRITE;
        k_d     = 3'd0;
      end
      WRITE: begin
        k_d     = k_q + 3'd1;
        state_d = (k_q == 3'd7) ? HOLD : WRITE;
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered from the next state so they line up with the state register
  assign act     = (state_d == SETUP) || (state_d == WRITE) || (state_d == HOLD);
  assign csib_d  = state_d != WRITE;
  assign rdwrb_d = !act;
  assign busy_d  = act;
  assign done_d  = state_d == DONE;
  assign data_d  = (state_d == WRITE) ? word(k_d) : data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      sync_q  <= '0;
      csib_q  <= 1'b1;
      rdwrb_q <= 1'b1;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[0], key};
      csib_q  <= csib_d;
      rdwrb_q <= rdwrb_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign icap_csib  = csib_q;
  assign icap_rdwrb = rdwrb_q;
  assign icap_i     = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_icape2_iprog_ctrl.sv
// tb_icape2_iprog_ctrl: scoreboard bench for the ICAPE2 warm-boot sequencer with a 4-cycle debounce.
module tb_icape2_iprog_ctrl;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key = 1'b0;
  logic        icap_csib, icap_rdwrb, busy, done;
  logic [31:0] icap_i;
  logic [31:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          low_cnt = 0;
  int          busy_rises = 0;
  logic        busy_prev = 1'b0;

  icape2_iprog_ctrl #(.WBSTAR_ADDR(32'h0040_0000), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .key(key), .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb),
    .icap_i(icap_i), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] tbl [8];
    logic [31:0] w, r;
    tbl = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001,
            32'h00400000, 32'h30008001, 32'h0000000F, 32'h20000000};
    w = tbl[k];
    r = w;
`ifdef ICAPE2_BITSWAP_EN
    for (int by = 0; by < 4; by++)
      for (int i = 0; i < 8; i++) r[by*8 + i] = w[by*8 + 7 - i];
`endif
    return r;
  endfunction

  // scoreboard consumer: every csib-low cycle must carry the next expected word
  always @(negedge clk) begin
    if (!rst) begin
      if (icap_csib === 1'b0) begin
        low_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: icap_i=%h with no word expected", icap_i);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (icap_i !== e) begin
            fails++;
            $display("FAIL word: icap_i=%h expected %h", icap_i, e);
          end
        end
      end
      if (busy === 1'b1 && !busy_prev) busy_rises++;
      busy_prev = busy;
    end else busy_prev = 1'b0;
  end

  task automatic push_seq();
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_word(k));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key = 1'b0;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if ({icap_csib, icap_rdwrb, icap_i, busy, done} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset: csib=%b rdwrb=%b i=%h busy=%b done=%b expected 1 1 00000000 0 0",
                 icap_csib, icap_rdwrb, icap_i, busy, done);
      end
    end
    rst = 1'b0;
  endtask

  // caller is at a negedge; the next posedge is e0
  task automatic press_and_check(input string name);
    logic eb, ec, er, ed;
    key = 1'b1;
    push_seq();
    @(posedge clk);
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      eb = (n >= D + 1) && (n <= D + 10);
      ec = !((n >= D + 2) && (n <= D + 9));
      er = !eb;
      ed = (n == D + 11);
      tests++;
      if ({busy, icap_csib, icap_rdwrb, done} !== {eb, ec, er, ed}) begin
        fails++;
        $display("FAIL %s_timing n=%0d: busy=%b csib=%b rdwrb=%b done=%b expected %b %b %b %b",
                 name, n, busy, icap_csib, icap_rdwrb, done, eb, ec, er, ed);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d words left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic release_key(input int cycles);
    key = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_short_press();
    int bad = 0;
    repeat (5) begin
      key = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (icap_csib !== 1'b1 || busy !== 1'b0) bad++;
      end
      key = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (icap_csib !== 1'b1 || busy !== 1'b0) bad++;
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (icap_csib !== 1'b1 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL short_press: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_long_hold();
    low_cnt = 0;
    busy_rises = 0;
    key = 1'b1;
    push_seq();
    repeat (200) @(negedge clk);
    tests++;
    if (low_cnt != 8 || busy_rises != 1) begin
      fails++;
      $display("FAIL long_hold: csib_low=%0d busy_rises=%0d expected 8 1", low_cnt, busy_rises);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL long_hold_drain: %0d words left, expected 0", exp_q.size());
      exp_q.delete();
    end
    release_key(2);
    press_and_check("repress");
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    release_key(3);
    key = 1'b1;
    push_seq();
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (icap_csib === 1'b0 && icap_i === exp_word(3)) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reset_mid_wait: WBSTAR write word %h not seen within 40 cycles", exp_word(3));
    end
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    tests++;
    if ({icap_csib, icap_rdwrb, busy, done, icap_i} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_mid: csib=%b rdwrb=%b busy=%b done=%b i=%h expected 1 1 0 0 00000000",
               icap_csib, icap_rdwrb, busy, done, icap_i);
    end
    rst = 1'b0;
    press_and_check("after_reset");
  endtask

  initial begin
    test_reset();
    press_and_check("press");
    release_key(3);
    test_short_press();
    test_long_hold();
    test_reset_mid();
    release_key(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
